mem_port_arbiter: RTL and testbench

//  Shares the single-port unified memory (1-cycle registered read, byte-enable write) between
//  the core's instruction-fetch port (I) and load/store port (D). Grants at most one access per

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter_starve_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    // Owner of the memory read issued in the previous cycle.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_IFETCH = 2'd1,
        OWN_LOAD   = 2'd2,
        OWN_STORE  = 2'd3
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter.
// slave: the arbiter's view; master: requesters plus memory.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_ready;
    logic              i_rsp_valid;
    logic [DATA_W-1:0] i_rsp_data;

    logic              d_req_valid;
    logic              d_req_we;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic [STRB_W-1:0] d_req_wstrb;
    logic              d_req_ready;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;

    logic              mem_read_ready;
    logic [ADDR_W-1:0] mem_read_address;
    logic              mem_write_ready;
    logic [ADDR_W-1:0] mem_write_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [STRB_W-1:0] mem_write_byte;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_read_ready, mem_read_address,
        output mem_write_ready, mem_write_address, mem_write_data, mem_write_byte,
        input  mem_read_data
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_read_ready, mem_read_address,
        input  mem_write_ready, mem_write_address, mem_write_data, mem_write_byte,
        output mem_read_data
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter of consecutive cycles the fetch port was denied.
module arb_starve_counter #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned W     = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] LIMIT_V = LIMIT[W-1:0];

    assign sat = (cnt == LIMIT_V);

    // Count denied cycles, hold at LIMIT, clear takes priority.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and load/store (D).
// D wins contention unless I has been starved STARVE_LIMIT cycles in a row.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    owner_e           owner_q;
    owner_e           owner_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             force_i;
    logic             grant_i;
    logic             grant_d;
    logic             starve_inc;
    logic             starve_clr;

    assign starve_inc = bus.i_req_valid & ~grant_i;
    assign starve_clr = grant_i | ~bus.i_req_valid;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .cnt   (starve_cnt),
        .sat   (force_i)
    );

    // Grant selection, memory command mux and next owner.
    always_comb begin
        grant_i               = 1'b0;
        grant_d               = 1'b0;
        owner_d               = OWN_NONE;
        bus.mem_read_ready    = 1'b0;
        bus.mem_read_address  = '0;
        bus.mem_write_ready   = 1'b0;
        bus.mem_write_address = '0;
        bus.mem_write_data    = '0;
        bus.mem_write_byte    = '0;

        if (!reset) begin
            grant_i = bus.i_req_valid & (force_i | ~bus.d_req_valid);
            grant_d = bus.d_req_valid & ~grant_i;
        end

        if (grant_i) begin
            owner_d              = OWN_IFETCH;
            bus.mem_read_ready   = 1'b1;
            bus.mem_read_address = bus.i_req_addr;
        end else if (grant_d && !bus.d_req_we) begin
            owner_d              = OWN_LOAD;
            bus.mem_read_ready   = 1'b1;
            bus.mem_read_address = bus.d_req_addr;
        end else if (grant_d) begin
            owner_d               = OWN_STORE;
            bus.mem_write_ready   = 1'b1;
            bus.mem_write_address = bus.d_req_addr;
            bus.mem_write_data    = bus.d_req_wdata;
            bus.mem_write_byte    = bus.d_req_wstrb;
        end
    end

    // Owner register: which requester the memory's read data belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Response decode; gating with reset drops a read in flight at reset.
    always_comb begin
        bus.i_req_ready = grant_i;
        bus.d_req_ready = grant_d;
        bus.i_rsp_valid = ~reset & (owner_q == OWN_IFETCH);
        bus.d_rsp_valid = ~reset & (owner_q == OWN_LOAD);
        bus.i_rsp_data  = bus.mem_read_data;
        bus.d_rsp_data  = bus.mem_read_data;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a queue scoreboard on responses.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   failed = 0;

    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] mem [0:63];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, byte-enable write at the edge.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 | i;
        mem[8] = 32'h1122_3344;
    end

    always @(posedge clk) begin
        if (bus.mem_read_ready) bus.mem_read_data <= mem[bus.mem_read_address[5:0]];
        if (bus.mem_write_ready) begin
            for (int unsigned b = 0; b < 4; b++)
                if (bus.mem_write_byte[b])
                    mem[bus.mem_write_address[5:0]][b*8 +: 8] <= bus.mem_write_data[b*8 +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.i_rsp_valid) begin
            if (exp_i_q.size() == 0) chk("i_rsp_unexpected", 32'd1, 32'd0);
            else chk("i_rsp_data", bus.i_rsp_data, exp_i_q.pop_front());
        end
        if (bus.d_rsp_valid) begin
            if (exp_d_q.size() == 0) chk("d_rsp_unexpected", 32'd1, 32'd0);
            else chk("d_rsp_data", bus.d_rsp_data, exp_d_q.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        bus.d_req_we    = 1'b0;
    endtask

    initial begin
        bus.mem_read_data = '0;
        bus.i_req_valid   = 1'b1;
        bus.i_req_addr    = 30'h10;
        bus.d_req_valid   = 1'b1;
        bus.d_req_we      = 1'b0;
        bus.d_req_addr    = 30'h20;
        bus.d_req_wdata   = '0;
        bus.d_req_wstrb   = '0;

        // 1: reset held 3 cycles with both requests valid
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_ready", {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd0);
            chk("rst_rsp", {30'd0, bus.i_rsp_valid, bus.d_rsp_valid}, 32'd0);
            chk("rst_mem_en", {30'd0, bus.mem_read_ready, bus.mem_write_ready}, 32'd0);
            next_cycle();
        end
        reset = 1'b0;
        idle();
        bus.i_req_addr  = 30'h3F;
        bus.d_req_addr  = 30'h3E;
        bus.d_req_wdata = 32'hFFFF_FFFF;
        bus.d_req_wstrb = 4'hF;
        @(negedge clk);
        // invalid requests are ignored regardless of payload
        chk("idle_mem_en", {30'd0, bus.mem_read_ready, bus.mem_write_ready}, 32'd0);
        chk("idle_mem_addr", {2'b0, bus.mem_read_address | bus.mem_write_address}, 32'd0);
        chk("idle_mem_wdata", bus.mem_write_data, 32'd0);
        next_cycle();

        // 2: fetch only
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 30'h10;
        @(negedge clk);
        chk("i_only_ready", {31'd0, bus.i_req_ready}, 32'd1);
        chk("i_only_raddr", {2'b0, bus.mem_read_address}, 32'h10);
        exp_i_q.push_back(32'hA5A5_0010);
        next_cycle();
        idle();
        next_cycle();

        // 3: contention, load wins then fetch follows
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 30'h14;
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'b0;
        bus.d_req_addr  = 30'h20;
        @(negedge clk);
        chk("cont_ready", {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd1);
        chk("cont_raddr", {2'b0, bus.mem_read_address}, 32'h20);
        exp_d_q.push_back(32'hA5A5_0020);
        next_cycle();
        bus.d_req_valid = 1'b0;
        @(negedge clk);
        chk("cont_i_ready", {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd2);
        exp_i_q.push_back(32'hA5A5_0014);
        next_cycle();
        idle();
        next_cycle();

        // 4: starvation: I denied 4 cycles, forced on the 5th
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 30'h28;
        bus.d_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.d_req_addr = 30'h30 + 30'(k);
            @(negedge clk);
            chk("starve_cnt", {29'd0, dut.starve_cnt}, 32'(k));
            chk("starve_deny", {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd1);
            exp_d_q.push_back(32'hA5A5_0030 + 32'(k));
            next_cycle();
        end
        bus.d_req_addr = 30'h34;
        @(negedge clk);
        chk("starve_cnt_sat", {29'd0, dut.starve_cnt}, 32'd4);
        chk("starve_force", {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd2);
        exp_i_q.push_back(32'hA5A5_0028);
        next_cycle();
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        chk("starve_cnt_clr", {29'd0, dut.starve_cnt}, 32'd0);
        chk("starve_d_held", {30'd0, bus.i_req_ready, bus.d_req_ready}, 32'd1);
        exp_d_q.push_back(32'hA5A5_0034);
        next_cycle();
        idle();
        next_cycle();

        // 5: partial store then load of the same word
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'b1;
        bus.d_req_addr  = 30'h08;
        bus.d_req_wdata = 32'hDEAD_BEEF;
        bus.d_req_wstrb = 4'b0011;
        @(negedge clk);
        chk("st_en", {30'd0, bus.mem_read_ready, bus.mem_write_ready}, 32'd1);
        chk("st_wbyte", {28'd0, bus.mem_write_byte}, 32'h3);
        chk("st_wdata", bus.mem_write_data, 32'hDEAD_BEEF);
        next_cycle();
        bus.d_req_we = 1'b0;
        @(negedge clk);
        chk("ld_after_st_en", {30'd0, bus.mem_read_ready, bus.mem_write_ready}, 32'd2);
        exp_d_q.push_back(32'h1122_BEEF);
        next_cycle();
        idle();
        next_cycle();

        // 6: reset right after a fetch grant drops its response
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 30'h10;
        @(negedge clk);
        chk("mid_i_ready", {31'd0, bus.i_req_ready}, 32'd1);
        next_cycle();
        reset = 1'b1;
        idle();
        @(negedge clk);
        chk("mid_rst_rsp", {31'd0, bus.i_rsp_valid}, 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_post_rsp", {31'd0, bus.i_rsp_valid}, 32'd0);
        chk("mid_owner", {30'd0, dut.owner_q}, 32'd0);
        next_cycle();
        next_cycle();

        chk("i_queue_drained", 32'(exp_i_q.size()), 32'd0);
        chk("d_queue_drained", 32'(exp_d_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
